// File: rtl/tq_quant4x4.sv
// tq_quant4x4: forward quantizer for H.264 4x4 integer-DCT residual blocks.
// Takes 16 raster-order coefficients per block and produces signed levels,
// a last-of-block marker and the block's running nonzero count through a
// two-stage valid/ready pipeline.

module tq_quant4x4 #(
    parameter int COEF_W  = 16,
    parameter int LEVEL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         qp_div_i,
    input  logic [2:0]         qp_mod_i,
    input  logic               intra_i,
    input  logic               coef_valid_i,
    output logic               coef_ready_o,
    input  logic [COEF_W-1:0]  coef_i,
    output logic               level_valid_o,
    input  logic               level_ready_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic               level_last_o,
    output logic [4:0]         nz_cnt_o
);

    localparam int          AW      = COEF_W + 1;
    localparam logic [31:0] LVL_MAX = (32'd1 << (LEVEL_W - 1)) - 32'd1;

    // Multiplication factor for one coefficient class at one qp remainder.
    // cls: 0 = both row/col even, 1 = both odd, 2 = mixed.
    function automatic logic [13:0] mf_lookup(input logic [1:0] cls, input logic [2:0] qm);
        logic [13:0] mf;
        mf = 14'd0;
        case (cls)
            2'd0: case (qm)
                      3'd0:    mf = 14'd13107;
                      3'd1:    mf = 14'd11916;
                      3'd2:    mf = 14'd10082;
                      3'd3:    mf = 14'd9362;
                      3'd4:    mf = 14'd8192;
                      default: mf = 14'd7282;
                  endcase
            2'd1: case (qm)
                      3'd0:    mf = 14'd5243;
                      3'd1:    mf = 14'd4660;
                      3'd2:    mf = 14'd4194;
                      3'd3:    mf = 14'd3647;
                      3'd4:    mf = 14'd3355;
                      default: mf = 14'd2893;
                  endcase
            default: case (qm)
                      3'd0:    mf = 14'd8066;
                      3'd1:    mf = 14'd7490;
                      3'd2:    mf = 14'd6554;
                      3'd3:    mf = 14'd5825;
                      3'd4:    mf = 14'd5243;
                      default: mf = 14'd4559;
                  endcase
        endcase
        return mf;
    endfunction

    // Intra rounding offset floor(2^(15+qd)/3); the inter offset is half of it.
    function automatic logic [31:0] f3_lookup(input logic [3:0] qd);
        logic [31:0] f;
        case (qd)
            4'd0:    f = 32'd10922;
            4'd1:    f = 32'd21845;
            4'd2:    f = 32'd43690;
            4'd3:    f = 32'd87381;
            4'd4:    f = 32'd174762;
            4'd5:    f = 32'd349525;
            4'd6:    f = 32'd699050;
            4'd7:    f = 32'd1398101;
            default: f = 32'd2796202;
        endcase
        return f;
    endfunction

    logic [3:0]    idx;
    logic [3:0]    qd_lat;
    logic [2:0]    qm_lat;
    logic          intra_lat;

    logic          s1_valid;
    logic          s1_sign;
    logic          s1_intra;
    logic          s1_last;
    logic [3:0]    s1_qd;
    logic [31:0]   s1_prod;

    logic [4:0]    nz_acc;

    logic          in_xfer;
    logic          out_xfer;
    logic          s1_adv;
    logic [3:0]    qd_fix;
    logic [2:0]    qm_fix;
    logic [3:0]    qd_cur;
    logic [2:0]    qm_cur;
    logic          intra_cur;
    logic [1:0]    cls;
    logic [AW-1:0] w_ext;
    logic [AW-1:0] w_abs;
    logic [31:0]   prod;

    logic [4:0]         qbits;
    logic [31:0]        f3;
    logic [31:0]        f_off;
    logic [31:0]        sum;
    logic [31:0]        mag;
    logic [31:0]        mag_sat;
    logic [LEVEL_W-1:0] lvl_mag;
    logic [LEVEL_W-1:0] lvl;
    logic               nz_inc;
    logic [4:0]         nz_base;
    logic [4:0]         nz_next;

    // Handshakes: S1 moves into S2 whenever S2 is empty or being drained.
    always_comb begin
        in_xfer      = coef_valid_i & coef_ready_o;
        out_xfer     = level_valid_o & level_ready_i;
        s1_adv       = s1_valid & (~level_valid_o | level_ready_i);
        coef_ready_o = ~s1_valid | s1_adv;
    end

    // Front end: pick the block's qp/mode, classify the position and form |W|*MF.
    always_comb begin
        qd_fix    = (qp_div_i > 4'd8) ? 4'd8 : qp_div_i;
        qm_fix    = (qp_mod_i > 3'd5) ? 3'd0 : qp_mod_i;
        qd_cur    = (idx == 4'd0) ? qd_fix  : qd_lat;
        qm_cur    = (idx == 4'd0) ? qm_fix  : qm_lat;
        intra_cur = (idx == 4'd0) ? intra_i : intra_lat;
        if (!idx[2] && !idx[0])
            cls = 2'd0;
        else if (idx[2] && idx[0])
            cls = 2'd1;
        else
            cls = 2'd2;
        w_ext = {coef_i[COEF_W-1], coef_i};
        w_abs = coef_i[COEF_W-1] ? -w_ext : w_ext;
        prod  = 32'(w_abs) * 32'(mf_lookup(cls, qm_cur));
    end

    // Back end: round, shift, saturate and restore the sign.
    always_comb begin
        qbits   = 5'd15 + {1'b0, s1_qd};
        f3      = f3_lookup(s1_qd);
        f_off   = s1_intra ? f3 : (f3 >> 1);
        sum     = s1_prod + f_off;
        mag     = sum >> qbits;
        mag_sat = (mag > LVL_MAX) ? LVL_MAX : mag;
        lvl_mag = mag_sat[LEVEL_W-1:0];
        lvl     = s1_sign ? -lvl_mag : lvl_mag;
        nz_inc  = (mag_sat != 32'd0);
        nz_base = (out_xfer && level_last_o) ? 5'd0 : nz_acc;
        nz_next = nz_base + {4'd0, nz_inc};
    end

    // Position counter and per-block qp/mode capture on the first coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 4'd0;
            qd_lat    <= 4'd0;
            qm_lat    <= 3'd0;
            intra_lat <= 1'b0;
        end else if (in_xfer) begin
            idx <= idx + 4'd1;
            if (idx == 4'd0) begin
                qd_lat    <= qd_fix;
                qm_lat    <= qm_fix;
                intra_lat <= intra_i;
            end
        end
    end

    // Stage 1: hold the product and the context needed to finish the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_intra <= 1'b0;
            s1_last  <= 1'b0;
            s1_qd    <= 4'd0;
            s1_prod  <= 32'd0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_sign  <= coef_i[COEF_W-1];
                s1_intra <= intra_cur;
                s1_last  <= (idx == 4'd15);
                s1_qd    <= qd_cur;
                s1_prod  <= prod;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: output register plus the block's running nonzero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_valid_o <= 1'b0;
            level_o       <= '0;
            level_last_o  <= 1'b0;
            nz_cnt_o      <= 5'd0;
            nz_acc        <= 5'd0;
        end else begin
            if (s1_adv) begin
                level_valid_o <= 1'b1;
                level_o       <= lvl;
                level_last_o  <= s1_last;
                nz_cnt_o      <= nz_next;
                nz_acc        <= nz_next;
            end else begin
                if (out_xfer)
                    level_valid_o <= 1'b0;
                if (out_xfer && level_last_o)
                    nz_acc <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_tq_quant4x4.sv
// Testbench for tq_quant4x4: directed blocks with hand-computed levels,
// scoreboard queue filled at issue time and drained by an output monitor.
// A second instance with LEVEL_W=12 runs in lockstep to exercise saturation.

module tb_tq_quant4x4;

    typedef int vec_t [16];

    typedef struct {
        int lvl;
        bit last;
        int nz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  qp_div_i;
    logic [2:0]  qp_mod_i;
    logic        intra_i;
    logic        coef_valid_i;
    logic        coef_ready_o;
    logic [15:0] coef_i;
    logic        level_valid_o;
    logic        level_ready_i;
    logic [15:0] level_o;
    logic        level_last_o;
    logic [4:0]  nz_cnt_o;

    logic        coef_ready12;
    logic        level_valid12;
    logic [11:0] level12;
    logic        level_last12;
    logic [4:0]  nz_cnt12;

    int   checks;
    int   failures;
    int   cycle;
    int   out_total;
    int   pop_cycles [$];
    exp_t sb [$];
    exp_t e;

    bit   hold_pending;
    int   held_lvl;
    bit   held_last;
    int   held_nz;

    vec_t wv;
    vec_t ev;

    tq_quant4x4 #(.COEF_W(16), .LEVEL_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .qp_div_i      (qp_div_i),
        .qp_mod_i      (qp_mod_i),
        .intra_i       (intra_i),
        .coef_valid_i  (coef_valid_i),
        .coef_ready_o  (coef_ready_o),
        .coef_i        (coef_i),
        .level_valid_o (level_valid_o),
        .level_ready_i (level_ready_i),
        .level_o       (level_o),
        .level_last_o  (level_last_o),
        .nz_cnt_o      (nz_cnt_o)
    );

    tq_quant4x4 #(.COEF_W(16), .LEVEL_W(12)) dut12 (
        .clk           (clk),
        .rst           (rst),
        .qp_div_i      (qp_div_i),
        .qp_mod_i      (qp_mod_i),
        .intra_i       (intra_i),
        .coef_valid_i  (coef_valid_i),
        .coef_ready_o  (coef_ready12),
        .coef_i        (coef_i),
        .level_valid_o (level_valid12),
        .level_ready_i (level_ready_i),
        .level_o       (level12),
        .level_last_o  (level_last12),
        .nz_cnt_o      (nz_cnt12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int clamp12(input int v);
        if (v > 2047)  return 2047;
        if (v < -2047) return -2047;
        return v;
    endfunction

    // Output monitor: checks hold stability under backpressure and pops the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", int'(level_valid_o), 1);
                checkOutput("hold_level", int'($signed(level_o)), held_lvl);
                checkOutput("hold_last", int'(level_last_o), int'(held_last));
                checkOutput("hold_nz", int'(nz_cnt_o), held_nz);
            end
            hold_pending = level_valid_o && !level_ready_i;
            held_lvl     = int'($signed(level_o));
            held_last    = level_last_o;
            held_nz      = int'(nz_cnt_o);
            if (level_valid_o && level_ready_i) begin
                out_total++;
                pop_cycles.push_back(cycle);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_level: actual=%0d required=none", $signed(level_o));
                end else begin
                    e = sb.pop_front();
                    checkOutput("level", int'($signed(level_o)), e.lvl);
                    checkOutput("last", int'(level_last_o), int'(e.last));
                    checkOutput("level12_valid", int'(level_valid12), 1);
                    checkOutput("level12", int'($signed(level12)), clamp12(e.lvl));
                    if (e.last) begin
                        checkOutput("nz_cnt", int'(nz_cnt_o), e.nz);
                        checkOutput("nz_cnt12", int'(nz_cnt12), e.nz);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int w, input int qd, input int qm, input bit intra,
                                 input int exp_lvl, input bit exp_last, input int exp_nz);
        int t;
        exp_t x;
        x.lvl  = exp_lvl;
        x.last = exp_last;
        x.nz   = exp_nz;
        sb.push_back(x);
        coef_i       = 16'(w);
        qp_div_i     = 4'(qd);
        qp_mod_i     = 3'(qm);
        intra_i      = intra;
        coef_valid_i = 1'b1;
        t = 0;
        while (!coef_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: actual=not_ready required=ready");
        end
        @(negedge clk);
        coef_valid_i = 1'b0;
    endtask

    task automatic runBlock(input vec_t w, input vec_t ex, input int qd, input int qm,
                            input bit intra, input int chg, input int qd2, input int qm2,
                            input bit intra2, input int nz);
        for (int i = 0; i < 16; i++) begin
            if (i < chg)
                applyStimulus(w[i], qd, qm, intra, ex[i], (i == 15), nz);
            else
                applyStimulus(w[i], qd2, qm2, intra2, ex[i], (i == 15), nz);
        end
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((sb.size() != 0 || level_valid_o) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, int'(level_valid_o), 0);
        checkOutput({tag, "_level"}, int'($signed(level_o)), 0);
        checkOutput({tag, "_last"}, int'(level_last_o), 0);
        checkOutput({tag, "_nz"}, int'(nz_cnt_o), 0);
        checkOutput({tag, "_valid12"}, int'(level_valid12), 0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #300000;
        checks++;
        failures++;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Main sequence of directed blocks.
    initial begin
        int base;
        int n;
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        out_total    = 0;
        hold_pending = 1'b0;
        rst          = 1'b1;
        coef_valid_i = 1'b0;
        coef_i       = 16'd0;
        qp_div_i     = 4'd0;
        qp_mod_i     = 3'd0;
        intra_i      = 1'b0;
        level_ready_i = 1'b1;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", int'(coef_ready_o), 1);
        checkOutput("ready12_after_reset", int'(coef_ready12), 1);
        @(negedge clk);

        $display("[TB] block: qp0 intra, W=-50 at idx0");
        wv = '{default: 0};
        ev = '{default: 0};
        wv[0] = -50; ev[0] = -20;
        runBlock(wv, ev, 0, 0, 1'b1, 16, 0, 0, 1'b0, 1);
        waitDrain();

        $display("[TB] block: qp0 inter, W=7 at idx5");
        wv = '{default: 0};
        ev = '{default: 0};
        wv[5] = 7; ev[5] = 1;
        runBlock(wv, ev, 0, 0, 1'b0, 16, 0, 0, 1'b0, 1);
        waitDrain();

        $display("[TB] back-to-back: zero block then clamped-qp block");
        wv = '{default: 0};
        ev = '{default: 0};
        runBlock(wv, ev, 0, 0, 1'b1, 16, 0, 0, 1'b0, 0);
        wv[0] = 32767;  ev[0] = 51;
        wv[15] = -32768; ev[15] = -20;
        runBlock(wv, ev, 15, 6, 1'b1, 16, 0, 0, 1'b0, 2);
        waitDrain();
        n = pop_cycles.size();
        if (n >= 32)
            checkOutput("no_bubble_span", pop_cycles[n-1] - pop_cycles[n-32], 31);
        else
            checkOutput("no_bubble_count", n, 32);

        $display("[TB] qp changed mid-block is ignored");
        wv = '{default: 0};
        ev = '{default: 0};
        wv[0] = 1000;  ev[0] = 25;
        wv[3] = -2000; ev[3] = -31;
        wv[5] = 1000;  ev[5] = 10;
        runBlock(wv, ev, 4, 0, 1'b1, 3, 0, 3, 1'b0, 3);
        waitDrain();

        $display("[TB] extreme inputs, 16-bit and 12-bit levels");
        wv = '{default: 0};
        ev = '{default: 0};
        wv[0] = 32767;  ev[0] = 13106;
        wv[1] = -32768; ev[1] = -8066;
        wv[2] = -32768; ev[2] = -13107;
        wv[5] = 4000;   ev[5] = 640;
        runBlock(wv, ev, 0, 0, 1'b1, 16, 0, 0, 1'b0, 4);
        waitDrain();

        $display("[TB] backpressure after third level");
        wv = '{300, -300, 300, -300, 300, -300, 300, -300,
               300, -300, 300, -300, 300, -300, 300, -300};
        ev = '{16, -10, 16, -10, 10, -6, 10, -6,
               16, -10, 16, -10, 10, -6, 10, -6};
        base = out_total;
        fork
            runBlock(wv, ev, 2, 5, 1'b0, 16, 0, 0, 1'b0, 16);
            begin
                int t;
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (out_total < base + 3 && t < 300);
                if (t >= 300)
                    checkOutput("bp_third_level_seen", out_total - base, 3);
                level_ready_i = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                checkOutput("coef_ready_stall", int'(coef_ready_o), 0);
                @(posedge clk);
                #1;
                level_ready_i = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_level_count", out_total - base, 16);

        $display("[TB] reset after 7 accepted inputs");
        wv = '{default: 0};
        ev = '{400, 246, 400, 246, 246, 160, 246, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++)
            applyStimulus(1000, 0, 0, 1'b1, ev[i], 1'b0, 0);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        checkResetState("midreset");
        checkOutput("midreset_ready", int'(coef_ready_o), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wv = '{default: 0};
        ev = '{default: 0};
        wv[0] = 100;   ev[0] = 15;
        wv[15] = -200; ev[15] = -12;
        runBlock(wv, ev, 1, 2, 1'b0, 16, 0, 0, 1'b0, 2);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
